// File: rtl/nvdla_rwsp_fifo_pkg.sv
// -----------------------------------------------------------------------------
// nvdla_rwsp_fifo_pkg
// Shared sizing constants for the RAM-backed FIFO controller and its output
// queue, plus the wrap-around index helper used by the output queue.
//   DEPTH     : RAM entries (power of two)
// AW        : RAM address width, log2(DEPTH)
//   DW        : data width
//   OQ_DEPTH  : output queue entries
//   CNT_W     : width of the total occupancy count (holds DEPTH+OQ_DEPTH)
// -----------------------------------------------------------------------------
package nvdla_rwsp_fifo_pkg;

   localparam int DEPTH     = 256;
   localparam int AW        = 8;
   localparam int DW        = 14;
   localparam int OQ_DEPTH  = 4;
   localparam int CNT_W     = AW + 2;
   localparam int RAM_CNT_W = AW + 1;
   localparam int OQ_CW     = $clog2(OQ_DEPTH + 1);
   localparam int OQ_PW     = $clog2(OQ_DEPTH);

   // Next slot of the output queue ring; written generically so OQ_DEPTH
   // does not have to be a power of two.
   function automatic logic [OQ_PW-1:0] oq_next(input logic [OQ_PW-1:0] idx);
      logic [OQ_PW-1:0] nxt;
      nxt = '0;
      if (idx != OQ_PW'(OQ_DEPTH - 1)) begin
         nxt = idx + 1'b1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/nvdla_rwsp_fifo_oq.sv
// -----------------------------------------------------------------------------
// nvdla_rwsp_fifo_oq
// Small flop-based FIFO that absorbs the two-cycle RAM read pipeline so the
// consumer sees one entry per cycle. Simultaneous push and pop are allowed at
// any occupancy, including full.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : capture i_data at the tail
//   i_data     : data to capture
//   i_pop      : drop the head entry (ignored when empty)
//   o_count    : number of entries held
//   o_head     : data at the head (0 after reset)
// -----------------------------------------------------------------------------
module nvdla_rwsp_fifo_oq
   import nvdla_rwsp_fifo_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [DW-1:0]    i_data,
   input  logic             i_pop,
   output logic [OQ_CW-1:0] o_count,
   output logic [DW-1:0]    o_head
);

   logic [DW-1:0]    r_mem [OQ_DEPTH];
   logic [OQ_PW-1:0] r_wr_idx;
   logic [OQ_PW-1:0] r_rd_idx;
   logic [OQ_CW-1:0] r_count;
   logic [OQ_CW-1:0] w_count_next;
   logic             w_pop;

   assign w_pop = i_pop && (r_count != '0);

   always_comb begin
      w_count_next = r_count;
      case ({i_push, w_pop})
         2'b10:   w_count_next = r_count + 1'b1;
         2'b01:   w_count_next = r_count - 1'b1;
         default: w_count_next = r_count;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < OQ_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_idx <= '0;
         r_rd_idx <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_idx] <= i_data;
            r_wr_idx        <= oq_next(r_wr_idx);
         end
         if (w_pop) begin
            r_rd_idx <= oq_next(r_rd_idx);
         end
         r_count <= w_count_next;
      end
   end

   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_idx];

   // The parent's read-issue credit rule must keep us from overflowing.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(i_push && !w_pop && (r_count == OQ_CW'(OQ_DEPTH))));

endmodule

// File: rtl/nvdla_rwsp_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// nvdla_rwsp_fifo_ctrl
// Valid/ready FIFO controller that drives an external 256xDW two-port RAM
// (registered read address on ram_re, registered output on ram_ore) as a
// queue, with a small output queue hiding the two-cycle read latency.
//   nvdla_core_clk / nvdla_core_rstn : clock, asynchronous active-low reset
//   wr_pvld / wr_prdy / wr_pd        : producer side
//   rd_pvld / rd_prdy / rd_pd        : consumer side (head of output queue)
//   fifo_count                       : entries held (RAM + in flight + OQ)
//   ram_we / ram_wa / ram_di         : RAM write port
//   ram_re / ram_ra / ram_ore        : RAM read address latch / output reg
//   ram_dout                         : RAM registered output
// -----------------------------------------------------------------------------
module nvdla_rwsp_fifo_ctrl
   import nvdla_rwsp_fifo_pkg::*;
(
   input  logic             nvdla_core_clk,
   input  logic             nvdla_core_rstn,
   input  logic             wr_pvld,
   output logic             wr_prdy,
   input  logic [DW-1:0]    wr_pd,
   output logic             rd_pvld,
   input  logic             rd_prdy,
   output logic [DW-1:0]    rd_pd,
   output logic [CNT_W-1:0] fifo_count,
   output logic             ram_we,
   output logic [AW-1:0]    ram_wa,
   output logic [DW-1:0]    ram_di,
   output logic             ram_re,
   output logic [AW-1:0]    ram_ra,
   output logic             ram_ore,
   input  logic [DW-1:0]    ram_dout
);

   logic [AW-1:0]        r_wr_ptr;
   logic [AW-1:0]        r_rd_ptr;
   logic [RAM_CNT_W-1:0] r_ram_cnt;
   logic                 r_re_d1;
   logic                 r_re_d2;

   logic                 w_push;
   logic                 w_issue;
   logic                 w_pop;
   logic [OQ_CW-1:0]     w_oq_cnt;
   logic [OQ_CW:0]       w_credit_used;

   // Ready depends only on registered occupancy, never on wr_pvld.
   assign wr_prdy = (r_ram_cnt != RAM_CNT_W'(DEPTH));
   assign w_push  = wr_pvld && wr_prdy;

   // An issued read owns an OQ slot from the cycle after issue until popped,
   // so OQ entries plus in-flight reads must stay below OQ_DEPTH to issue.
   assign w_credit_used = {1'b0, w_oq_cnt} + (OQ_CW+1)'(r_re_d1) + (OQ_CW+1)'(r_re_d2);
   assign w_issue       = (r_ram_cnt != '0) && (w_credit_used < (OQ_CW+1)'(OQ_DEPTH));

   assign ram_we  = w_push;
   assign ram_wa  = r_wr_ptr;
   assign ram_di  = w_push ? wr_pd : '0;
   assign ram_re  = w_issue;
   assign ram_ra  = r_rd_ptr;
   assign ram_ore = r_re_d1;

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_ram_cnt <= '0;
         r_re_d1   <= 1'b0;
         r_re_d2   <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_issue) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_issue})
            2'b10:   r_ram_cnt <= r_ram_cnt + 1'b1;
            2'b01:   r_ram_cnt <= r_ram_cnt - 1'b1;
            default: r_ram_cnt <= r_ram_cnt;
         endcase
         r_re_d1 <= w_issue;
         r_re_d2 <= r_re_d1;
      end
   end

   assign rd_pvld = (w_oq_cnt != '0);
   assign w_pop   = rd_pvld && rd_prdy;

   // r_re_d2 marks the cycle in which ram_dout carries the issued entry.
   nvdla_rwsp_fifo_oq u_oq (
      .clk     (nvdla_core_clk),
      .rst_n   (nvdla_core_rstn),
      .i_push  (r_re_d2),
      .i_data  (ram_dout),
      .i_pop   (w_pop),
      .o_count (w_oq_cnt),
      .o_head  (rd_pd)
   );

   assign fifo_count = CNT_W'(r_ram_cnt) + CNT_W'(w_oq_cnt)
                     + CNT_W'(r_re_d1) + CNT_W'(r_re_d2);

endmodule
